// File: rtl/ysyx_23060025_csr_trap_if.sv
// CSR access, trap/return and redirect signals between the execute stage
// and the machine-mode CSR/trap block.
interface ysyx_23060025_csr_trap_if #(
  parameter int DATA_WIDTH = 32
);
  logic [1:0]            csr_op_i;
  logic [11:0]           csr_addr_i;
  logic [DATA_WIDTH-1:0] csr_wdata_i;
  logic [DATA_WIDTH-1:0] csr_rdata_o;
  logic                  csr_illegal_o;
  logic                  trap_valid_i;
  logic [DATA_WIDTH-1:0] trap_cause_i;
  logic [DATA_WIDTH-1:0] trap_pc_i;
  logic                  mret_i;
  logic                  int_boundary_i;
  logic                  irq_timer_i;
  logic                  irq_pending_o;
  logic                  redirect_valid_o;
  logic [DATA_WIDTH-1:0] redirect_pc_o;

  modport master (
    output csr_op_i, csr_addr_i, csr_wdata_i, trap_valid_i, trap_cause_i,
           trap_pc_i, mret_i, int_boundary_i, irq_timer_i,
    input  csr_rdata_o, csr_illegal_o, irq_pending_o, redirect_valid_o,
           redirect_pc_o
  );

  modport slave (
    input  csr_op_i, csr_addr_i, csr_wdata_i, trap_valid_i, trap_cause_i,
           trap_pc_i, mret_i, int_boundary_i, irq_timer_i,
    output csr_rdata_o, csr_illegal_o, irq_pending_o, redirect_valid_o,
           redirect_pc_o
  );
endinterface

// File: rtl/ysyx_23060025_csr_trap.sv
// Machine-mode CSR file with Zicsr read-modify-write, trap entry, mret,
// gated timer interrupt, 64-bit mcycle and a registered fetch redirect.
module ysyx_23060025_csr_trap #(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_MTVEC = '0,
  parameter logic [31:0]           MVENDORID   = 32'h79737978,
  parameter logic [31:0]           MARCHID     = 32'd23060025,
  parameter logic [31:0]           MHARTID     = 32'd0
) (
  input logic                    clock,
  input logic                    reset,
  ysyx_23060025_csr_trap_if.slave bus
);
  localparam int DW = DATA_WIDTH;
  typedef logic [DW-1:0] word_t;
  localparam word_t INT_CAUSE = {1'b1, {(DW-1){1'b0}}} | word_t'(7);

  logic        mie_q, mpie_q, mtie_q;
  word_t       mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [63:0] mcycle_q, mcycle_d;
  logic        redirect_valid_q;
  word_t       redirect_pc_q;

  word_t rdata, wval, trap_base;
  logic  impl, illegal, irq_pending;
  logic  take_trap, take_mret, take_int, csr_we;

  always_comb begin
    rdata = '0;
    impl  = 1'b1;
    case (bus.csr_addr_i)
      12'h300: begin
        rdata[12:11] = 2'b11;
        rdata[7]     = mpie_q;
        rdata[3]     = mie_q;
      end
      12'h304: rdata[7] = mtie_q;
      12'h305: rdata = mtvec_q;
      12'h340: rdata = mscratch_q;
      12'h341: rdata = mepc_q;
      12'h342: rdata = mcause_q;
      12'h344: rdata[7] = bus.irq_timer_i;
      12'hB00: rdata = word_t'(mcycle_q);
      12'hB80: begin
        if (DW == 32) rdata = word_t'(mcycle_q[63:32]);
        else          impl  = 1'b0;
      end
      12'hF11: rdata = word_t'(MVENDORID);
      12'hF12: rdata = word_t'(MARCHID);
      12'hF14: rdata = word_t'(MHARTID);
      default: impl = 1'b0;
    endcase
  end

  // Read-only space (addr[11:10]==11) tolerates only RS/RC with a zero mask.
  assign illegal = (bus.csr_op_i != 2'b00) &&
                   (!impl || (bus.csr_addr_i[11:10] == 2'b11 &&
                              (bus.csr_op_i == 2'b01 || bus.csr_wdata_i != '0)));

  always_comb begin
    case (bus.csr_op_i)
      2'b01:   wval = bus.csr_wdata_i;
      2'b10:   wval = rdata | bus.csr_wdata_i;
      2'b11:   wval = rdata & ~bus.csr_wdata_i;
      default: wval = rdata;
    endcase
  end

  assign irq_pending = mie_q & mtie_q & bus.irq_timer_i;
  assign take_trap   = bus.trap_valid_i;
  assign take_mret   = !take_trap && bus.mret_i;
  assign take_int    = !take_trap && !bus.mret_i && irq_pending && bus.int_boundary_i;
  assign csr_we      = (bus.csr_op_i != 2'b00) && !illegal &&
                       !take_trap && !bus.mret_i && !take_int;
  assign trap_base   = {mtvec_q[DW-1:2], 2'b00};

  // A write to either mcycle half replaces the whole next value, so the
  // dropped increment cannot carry into the other half.
  always_comb begin
    mcycle_d = mcycle_q + 64'd1;
    if (csr_we && bus.csr_addr_i == 12'hB00)
      mcycle_d = (DW == 32) ? {mcycle_q[63:32], wval[31:0]} : 64'(wval);
    if (csr_we && bus.csr_addr_i == 12'hB80)
      mcycle_d = {wval[31:0], mcycle_q[31:0]};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mie_q            <= 1'b0;
      mpie_q           <= 1'b0;
      mtie_q           <= 1'b0;
      mtvec_q          <= RESET_MTVEC;
      mscratch_q       <= '0;
      mepc_q           <= '0;
      mcause_q         <= '0;
      mcycle_q         <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      mcycle_q         <= mcycle_d;
      redirect_valid_q <= 1'b0;
      if (take_trap || take_int) begin
        mepc_q           <= bus.trap_pc_i & ~word_t'(3);
        mpie_q           <= mie_q;
        mie_q            <= 1'b0;
        mcause_q         <= take_trap ? bus.trap_cause_i : INT_CAUSE;
        redirect_valid_q <= 1'b1;
        redirect_pc_q    <= trap_base + ((take_int && mtvec_q[0]) ? word_t'(28) : '0);
      end else if (take_mret) begin
        mie_q            <= mpie_q;
        mpie_q           <= 1'b1;
        redirect_valid_q <= 1'b1;
        redirect_pc_q    <= mepc_q;
      end else if (csr_we) begin
        case (bus.csr_addr_i)
          12'h300: begin
            mie_q  <= wval[3];
            mpie_q <= wval[7];
          end
          12'h304: mtie_q     <= wval[7];
          12'h305: mtvec_q    <= {wval[DW-1:2], 1'b0, wval[1:0] == 2'b01};
          12'h340: mscratch_q <= wval;
          12'h341: mepc_q     <= {wval[DW-1:2], 2'b00};
          12'h342: mcause_q   <= wval;
          default: ;
        endcase
      end
    end
  end

  assign bus.csr_rdata_o      = rdata;
  assign bus.csr_illegal_o    = illegal;
  assign bus.irq_pending_o    = irq_pending;
  assign bus.redirect_valid_o = redirect_valid_q;
  assign bus.redirect_pc_o    = redirect_pc_q;
endmodule

// File: tb/tb_ysyx_23060025_csr_trap.sv
// Directed bench for the CSR/trap block: expectations are queued when a
// stimulus step is driven and popped when the matching output is sampled.
module tb_ysyx_23060025_csr_trap;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ysyx_23060025_csr_trap_if #(.DATA_WIDTH(32)) bus ();
  ysyx_23060025_csr_trap #(.DATA_WIDTH(32)) dut (.clock(clock), .reset(reset), .bus(bus));

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  logic [31:0] cyc = 0;

  // Reference cycle count since reset, sampled between edges.
  always @(posedge clock) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic ex(input string t, input logic [31:0] v);
    exp_t e;
    e.tag = t;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.csr_op_i       = 2'b00;
    bus.csr_wdata_i    = '0;
    bus.trap_valid_i   = 1'b0;
    bus.trap_cause_i   = '0;
    bus.trap_pc_i      = '0;
    bus.mret_i         = 1'b0;
    bus.int_boundary_i = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] e, input string t);
    idle();
    bus.csr_addr_i = a;
    ex(t, e);
    smp();
    chk(bus.csr_rdata_o);
    tick();
  endtask

  // Read in the cycle after an event: redirect pair first, then the data.
  task automatic rdr(input logic [11:0] a, input logic [31:0] e, input string t);
    idle();
    bus.csr_addr_i = a;
    ex(t, e);
    smp();
    chk(32'(bus.redirect_valid_o));
    chk(bus.redirect_pc_o);
    chk(bus.csr_rdata_o);
    tick();
  endtask

  task automatic wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd,
                    input logic [31:0] old, input logic ill, input string t);
    idle();
    bus.csr_op_i    = op;
    bus.csr_addr_i  = a;
    bus.csr_wdata_i = wd;
    ex({t, "_old"}, old);
    ex({t, "_illegal"}, 32'(ill));
    smp();
    chk(bus.csr_rdata_o);
    chk(32'(bus.csr_illegal_o));
    tick();
  endtask

  task automatic trap(input logic [31:0] pc, input logic [31:0] cause, input logic [31:0] tgt);
    idle();
    bus.trap_valid_i = 1'b1;
    bus.trap_pc_i    = pc;
    bus.trap_cause_i = cause;
    ex("trap_rv", 1);
    ex("trap_rpc", tgt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    bus.csr_addr_i  = '0;
    bus.irq_timer_i = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset state and the first cycles after release
    bus.csr_addr_i = 12'h300;
    ex("rst_rv", 0); ex("rst_rpc", 0); ex("rst_pend", 0); ex("rst_mstatus", 32'h1800);
    smp();
    chk(32'(bus.redirect_valid_o)); chk(bus.redirect_pc_o);
    chk(32'(bus.irq_pending_o)); chk(bus.csr_rdata_o);
    tick();
    rd(12'hF11, 32'h79737978, "mvendorid");
    rd(12'hB00, 32'd2, "mcycle_after_reset");

    // mscratch read-modify-write
    wr(2'b01, 12'h340, 32'hA5A5_0000, 32'h0, 1'b0, "mscratch_rw");
    wr(2'b10, 12'h340, 32'h0000_00FF, 32'hA5A5_0000, 1'b0, "mscratch_rs");
    wr(2'b11, 12'h340, 32'hA500_0000, 32'hA5A5_00FF, 1'b0, "mscratch_rc");
    rd(12'h340, 32'h00A5_00FF, "mscratch_final");

    // ecall and mret
    wr(2'b01, 12'h305, 32'h8000_0100, 32'h0, 1'b0, "mtvec_direct");
    wr(2'b10, 12'h300, 32'h8, 32'h1800, 1'b0, "mstatus_set_mie");
    rd(12'h300, 32'h1808, "mstatus_mie1");
    trap(32'h8000_0010, 32'd11, 32'h8000_0100);
    smp(); tick();
    rdr(12'h341, 32'h8000_0010, "ecall_mepc");
    idle(); bus.csr_addr_i = 12'h342;
    ex("ecall_pulse_end", 0); ex("ecall_mcause", 32'd11);
    smp(); chk(32'(bus.redirect_valid_o)); chk(bus.csr_rdata_o); tick();
    rd(12'h300, 32'h1880, "ecall_mstatus");
    idle(); bus.mret_i = 1'b1;
    ex("mret_rv", 1); ex("mret_rpc", 32'h8000_0010);
    smp(); tick();
    rdr(12'h300, 32'h1888, "mret_mstatus");

    // Vectored timer interrupt, then gated off by MIE = 0
    wr(2'b01, 12'h305, 32'h8000_0101, 32'h8000_0100, 1'b0, "mtvec_vec");
    wr(2'b10, 12'h304, 32'h80, 32'h0, 1'b0, "mie_mtie");
    idle(); bus.irq_timer_i = 1'b1; bus.int_boundary_i = 1'b1; bus.trap_pc_i = 32'h8000_0044;
    ex("int_pending", 1); ex("int_rv", 1); ex("int_rpc", 32'h8000_011C);
    smp(); chk(32'(bus.irq_pending_o)); tick();
    idle(); bus.csr_addr_i = 12'h342;
    ex("int_mcause", 32'h8000_0007); ex("int_pend_cleared", 0);
    smp(); chk(32'(bus.redirect_valid_o)); chk(bus.redirect_pc_o);
    chk(bus.csr_rdata_o); chk(32'(bus.irq_pending_o)); tick();
    idle(); bus.int_boundary_i = 1'b1; bus.csr_addr_i = 12'h344;
    ex("int_pulse_end", 0); ex("mip_mtip", 32'h80);
    smp(); chk(32'(bus.redirect_valid_o)); chk(bus.csr_rdata_o); tick();
    idle(); bus.csr_addr_i = 12'h300;
    ex("int_gated_rv", 0); ex("int_mstatus", 32'h1880);
    smp(); chk(32'(bus.redirect_valid_o)); chk(bus.csr_rdata_o); tick();
    bus.irq_timer_i = 1'b0;

    // Illegal accesses
    wr(2'b01, 12'hF11, 32'h5, 32'h79737978, 1'b1, "ro_rw");
    wr(2'b10, 12'hF12, 32'h1, 32'd23060025, 1'b1, "ro_rs_nz");
    wr(2'b10, 12'h7C0, 32'h0, 32'h0, 1'b1, "unimpl");
    wr(2'b10, 12'hF12, 32'h0, 32'd23060025, 1'b0, "ro_rs_zero");

    // Trap beats mret and a CSR write in the same cycle
    trap(32'h8000_0206, 32'd2, 32'h8000_0100);
    bus.mret_i = 1'b1; bus.csr_op_i = 2'b01; bus.csr_addr_i = 12'h341;
    bus.csr_wdata_i = 32'h1234_5678;
    smp(); tick();
    rdr(12'h341, 32'h8000_0204, "prio_mepc");
    rd(12'h342, 32'd2, "prio_mcause");
    rd(12'h300, 32'h1800, "prio_mstatus");

    // mcycle write drops that cycle's increment and carries into mcycleh
    idle(); bus.csr_op_i = 2'b01; bus.csr_addr_i = 12'hB00; bus.csr_wdata_i = 32'hFFFF_FFFF;
    ex("mcycle_old", cyc);
    smp(); chk(bus.csr_rdata_o); tick();
    rd(12'hB00, 32'hFFFF_FFFF, "mcycle_written");
    rd(12'hB80, 32'h1, "mcycleh_carry");

    // mret right after an mepc write uses the new value
    wr(2'b01, 12'h341, 32'h8000_0333, 32'h8000_0204, 1'b0, "mepc_wr");
    idle(); bus.mret_i = 1'b1;
    ex("mret2_rv", 1); ex("mret2_rpc", 32'h8000_0330);
    smp(); tick();
    rdr(12'h300, 32'h1880, "mret2_mstatus");

    // Back-to-back traps: two pulses, second saves MPIE = 0
    wr(2'b10, 12'h300, 32'h8, 32'h1880, 1'b0, "mstatus_set_mie2");
    trap(32'h8000_0400, 32'd3, 32'h8000_0100);
    smp(); tick();
    trap(32'h8000_0500, 32'd4, 32'h8000_0100);
    smp(); chk(32'(bus.redirect_valid_o)); chk(bus.redirect_pc_o); tick();
    rdr(12'h300, 32'h1800, "b2b_mstatus");
    idle(); bus.csr_addr_i = 12'h341;
    ex("b2b_pulse_end", 0); ex("b2b_mepc", 32'h8000_0500);
    smp(); chk(32'(bus.redirect_valid_o)); chk(bus.csr_rdata_o); tick();

    // Reset during a redirect pulse
    trap(32'h8000_0600, 32'd5, 32'h8000_0100);
    smp(); tick();
    idle(); reset = 1'b1;
    smp(); chk(32'(bus.redirect_valid_o)); chk(bus.redirect_pc_o); tick();
    reset = 1'b0;
    idle(); bus.csr_addr_i = 12'h305;
    ex("rst2_rv", 0); ex("rst2_rpc", 0); ex("rst2_mtvec", 0);
    smp(); chk(32'(bus.redirect_valid_o)); chk(bus.redirect_pc_o); chk(bus.csr_rdata_o); tick();
    rd(12'h300, 32'h1800, "rst2_mstatus");

    while (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL unconsumed %s expected=%h", e.tag, e.val);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ysyx_23060025_csr_trap.md
# ysyx_23060025_csr_trap

Machine-mode CSR file and trap controller for the ysyx_23060025 core, sitting beside the execute/writeback stage. It implements Zicsr read-modify-write semantics (CSRRW/CSRRS/CSRRC) and synchronous trap entry (ecall/exceptions). It also provides mret return, a gated machine-timer interrupt, and a free-running 64-bit mcycle counter. Trap and return targets go to the fetch stage as a registered one-cycle redirect.

## Interface
- DATA_WIDTH, 32: XLEN. Legal values are 32 and 64. mcycleh exists only when 32.
- RESET_MTVEC, 0: reset value of mtvec.
- MVENDORID, 32'h79737978: read-only mvendorid value.
- MARCHID, 32'd23060025: read-only marchid value.
- MHARTID, 0: read-only mhartid value.

Ports:
- clock  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- csr_op_i  in  2  00 none, 01 RW, 10 RS (set), 11 RC (clear).
- csr_addr_i  in  12  CSR address.
- csr_wdata_i  in  DATA_WIDTH  rs1 value or zero-extended immediate.
- csr_rdata_o  out  DATA_WIDTH  old value of the addressed CSR, combinational.
- csr_illegal_o  out  1  access illegal, combinational.
- trap_valid_i  in  1  synchronous exception/ecall this cycle.
- trap_cause_i  in  DATA_WIDTH  mcause value for the trap.
- trap_pc_i  in  DATA_WIDTH  pc of the trapping instruction, or next pc on an interrupt.
- mret_i  in  1  mret executing this cycle.
- int_boundary_i  in  1  core is at an instruction boundary and may take an interrupt.
- irq_timer_i  in  1  machine timer interrupt level (MTIP).
- irq_pending_o  out  1  MIE & MTIE & MTIP, combinational.
- redirect_valid_o  out  1  one-cycle pulse requesting fetch redirect, registered.
- redirect_pc_o  out  DATA_WIDTH  redirect target, registered.

## Operation
- Implemented CSRs:
  - mstatus 0x300: MIE[3], MPIE[7]; MPP[12:11] hardwired 2'b11; all other bits read 0.
  - mie 0x304: only MTIE[7] is writable.
  - mtvec 0x305: [1:0] mode, 0 = direct, 1 = vectored; mode values 2/3 are written as 0.
  - mscratch 0x340.
  - mepc 0x341: bits [1:0] are always 0.
  - mcause 0x342.
  - mip 0x344: read-only; MTIP[7] = irq_timer_i.
  - mcycle 0xB00 and mcycleh 0xB80.
  - mvendorid 0xF11, marchid 0xF12, mhartid 0xF14.
- Write value by op:
  - RW: new = wdata.
  - RS: new = old | wdata.
  - RC: new = old & ~wdata.
  - The write commits at the clock edge.
- csr_illegal_o is 1 when csr_op_i != 00 and any of these holds; an illegal access changes no state:
  - the address is unimplemented;
  - addr[11:10] == 2'b11 with op RW;
  - addr[11:10] == 2'b11 with RS/RC and wdata != 0.
- mcycle:
  - Increments by 1 every cycle.
  - A CSR write to mcycle or mcycleh replaces the addressed half; that cycle's increment is dropped.
  - The counter wraps at 2^64 - 1 to 0.
- Trap entry on trap_valid_i, or an interrupt taken when irq_pending_o & int_boundary_i:
  - Updates: mepc <= trap_pc_i & ~3; MPIE <= MIE; MIE <= 0.
  - mcause <= trap_cause_i for an exception. For an interrupt, mcause has MSB = 1 and low bits = 7.
  - redirect_pc_o <= {mtvec[DW-1:2], 2'b00}. For a vectored mode interrupt it is that base + 4*7.
- mret: MIE <= MPIE; MPIE <= 1; redirect_pc_o <= mepc.
- Priority within one cycle: trap_valid_i > mret_i > interrupt > CSR write. Every lower-priority event is dropped entirely, with no partial updates. mcycle still increments.

## Timing
- Reset values:
  - mstatus 0x1800, mtvec RESET_MTVEC.
  - mepc, mcause, mscratch, mie, mcycle all 0.
  - redirect_valid_o 0, redirect_pc_o 0.
- csr_rdata_o, csr_illegal_o and irq_pending_o are combinational with zero latency. A read in the same cycle as a write returns the old value.
- Trap, interrupt or mret in cycle N:
  - CSR updates are visible in N+1.
  - redirect_valid_o = 1 for exactly cycle N+1, with redirect_pc_o valid in that cycle.
  - redirect_pc_o holds its value afterwards.
- An mret immediately after a CSR write to mepc in cycle N-1 uses the new mepc.
- Back-to-back traps in N and N+1 produce two pulses. The second trap saves MPIE = 0.
- Reset asserted during an active redirect pulse forces redirect_valid_o = 0 at the next edge.

## Test plan
- After reset, read 0x300, 0xF11 and 0xB00 on consecutive cycles -> 0x1800, 0x79737978, and a count equal to the cycles since reset.
- mscratch: RW 0xA5A5_0000, then RS 0x0000_00FF, then RC 0xA500_0000 -> reads return 0, 0xA5A5_0000 and 0xA5A5_00FF. Final value is 0x00A5_00FF.
- mtvec = 0x8000_0100, MIE = 1; ecall at trap_pc_i 0x8000_0010 with cause 11 -> one-cycle redirect to 0x8000_0100; mepc = 0x8000_0010, mcause = 11, MIE = 0, MPIE = 1. A following mret -> redirect to 0x8000_0010 with MIE = 1.
- mtvec = 0x8000_0101, MIE = 1, MTIE = 1, irq_timer_i = 1, int_boundary_i = 1 -> redirect to 0x8000_011C; mcause = 0x8000_0007. With MIE = 0 -> no redirect.
- RW to 0xF11, RS to 0xF12 with wdata 1, and a read of 0x7C0 -> csr_illegal_o = 1 and no state change. RS to 0xF12 with wdata 0 -> legal.
- trap_valid_i, mret_i and a CSR RW to mepc in the same cycle -> only the trap takes effect, and mepc = trap_pc_i. Also write mcycle = 0xFFFF_FFFF; two cycles later mcycleh reads 1.
